// File: rtl/alu_result_stage.sv
// ALU result stage: registered valid/ready output stage behind the combinational ALU.
// A head register plus a skid register keep in_ready purely register-driven, so
// out_ready never reaches back to the ALU combinationally. It also keeps a sticky
// signed-overflow status and a wrapping count of output transfers.
// Optional feature: define ALU_RES_STATS_EN to add the ovf_count port and counter.
module alu_result_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_y,
    input  logic [3:0]       in_op,
    input  logic             in_carry,
    input  logic             in_overflow,
    input  logic             in_zero,
    input  logic             in_negative,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [3:0]       out_op,
    output logic [3:0]       out_flags,
    input  logic             clr_sticky,
    output logic             sticky_ovf,
    output logic [CNT_W-1:0] result_count
`ifdef ALU_RES_STATS_EN
    ,
    output logic [CNT_W-1:0] ovf_count
`endif
);

    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StOne   = 2'd1;
    localparam logic [1:0] StFull  = 2'd2;

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic             ready_q;
    logic [WIDTH-1:0] head_y_q, skid_y_q;
    logic [3:0]       head_op_q, skid_op_q;
    logic [3:0]       head_flags_q, skid_flags_q;
    logic             sticky_q;
    logic [CNT_W-1:0] count_q;

    logic       in_xfer, out_xfer;
    logic       load_head_in, load_head_skid, load_skid;
    logic [3:0] flags_in;
    logic       is_arith;

    assign flags_in  = {in_negative, in_zero, in_carry, in_overflow};
    assign is_arith  = (in_op == 4'd0) || (in_op == 4'd1);
    assign out_valid = (state_q != StEmpty);
    assign in_xfer   = in_valid & ready_q;
    assign out_xfer  = out_valid & out_ready;

    // Occupancy FSM: decide next state and which storage register loads from where.
    always_comb begin
        state_d        = state_q;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            StEmpty: begin
                if (in_xfer) begin
                    state_d      = StOne;
                    load_head_in = 1'b1;
                end
            end
            StOne: begin
                if (in_xfer && !out_xfer) begin
                    state_d   = StFull;
                    load_skid = 1'b1;
                end else if (in_xfer && out_xfer) begin
                    load_head_in = 1'b1;
                end else if (out_xfer) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                // in_ready is low here, so only the drain side can move
                if (out_xfer) begin
                    state_d        = StOne;
                    load_head_skid = 1'b1;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    // State and registered in_ready; ready stays low through reset until the first edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != StFull);
        end
    end

    // Head and skid storage; skid always holds the younger entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_y_q     <= '0;
            head_op_q    <= '0;
            head_flags_q <= '0;
            skid_y_q     <= '0;
            skid_op_q    <= '0;
            skid_flags_q <= '0;
        end else begin
            if (load_head_in) begin
                head_y_q     <= in_y;
                head_op_q    <= in_op;
                head_flags_q <= flags_in;
            end else if (load_head_skid) begin
                head_y_q     <= skid_y_q;
                head_op_q    <= skid_op_q;
                head_flags_q <= skid_flags_q;
            end
            if (load_skid) begin
                skid_y_q     <= in_y;
                skid_op_q    <= in_op;
                skid_flags_q <= flags_in;
            end
        end
    end

    // Sticky overflow for ADD/SUB; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else if (in_xfer && in_overflow && is_arith) begin
            sticky_q <= 1'b1;
        end else if (clr_sticky) begin
            sticky_q <= 1'b0;
        end
    end

    // Output transfer counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (out_xfer) begin
            count_q <= count_q + CntOne;
        end
    end

`ifdef ALU_RES_STATS_EN
    logic [CNT_W-1:0] ovf_cnt_q;

    // Overflow counter for any opcode; an increment alongside clr_sticky yields 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_q <= '0;
        end else if (in_xfer && in_overflow) begin
            ovf_cnt_q <= clr_sticky ? CntOne : ovf_cnt_q + CntOne;
        end else if (clr_sticky) begin
            ovf_cnt_q <= '0;
        end
    end

    assign ovf_count = ovf_cnt_q;
`endif

    assign in_ready     = ready_q;
    assign out_y        = head_y_q;
    assign out_op       = head_op_q;
    assign out_flags    = head_flags_q;
    assign sticky_ovf   = sticky_q;
    assign result_count = count_q;

endmodule
